cmb_event_collector: RTL and testbench
======================================

Name: cmb_event_collector

Overview:
- Sequential stage directly downstream of the 16-input `cmb` flag decoder. It consumes the decoder's four flag outputs (q, r, s, t) once per accepted sample.
- Change-detects the flag vector and logs each change as a timestamped event record in a small FIFO. The FIFO is drained over a valid/ready interface.
- Keeps saturating per-flag hit counters for status readout.

Parameters:
- CNT_W, 8, width of sample index and per-flag hit counters
- DEPTH, 4, event FIFO depth in entries (power of two, >= 2)

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous active-high reset
- clr  input  1  synchronous clear of counters, sample index, FIFO, and the have_prev flag
- in_valid  input  1  flag sample present
- in_ready  output  1  sample accepted this cycle when in_valid & in_ready
- q_in  input  1  decoder flag q (all-ones match)
- r_in  input  1  decoder flag r
- s_in  input  1  decoder flag s
- t_in  input  1  decoder flag t (all-zeros match)
- out_valid  output  1  event record available
- out_ready  input  1  consumer takes record when out_valid & out_ready
- out_data  output  4+CNT_W  {sample_idx[CNT_W-1:0], t, s, r, q}; flags occupy bits [3:0]
- hit_q, hit_r, hit_s, hit_t  output  CNT_W each  saturating count of accepted samples with that flag = 1
- sat  output  1  sticky: some hit counter reached all-ones

Behaviour:
- Reset (async, rst=1) values:
  - out_valid=0, in_ready=1, out_data=0.
  - All hit_* = 0, sat = 0, sample_idx = 0, have_prev = 0, FIFO empty.
- Handshakes:
  - in_ready = !fifo_full, registered-equivalent from FIFO state only; it does not depend on in_valid or out_ready.
  - Accept = in_valid & in_ready.
- Per accepted sample:
  - sample_idx increments by 1, wrapping from 2^CNT_W-1 to 0.
  - Each hit_* increments if its flag is 1, holding at all-ones.
  - sat sets when any counter becomes all-ones and stays set until rst or clr.
- Event generation:
  - An event is pushed if have_prev=0 (first sample after reset/clr) or {t,s,r,q} differs from the previous accepted vector.
  - Record = {sample_idx value before increment, flags}.
  - have_prev is set on the first accept; the previous vector updates on every accept.
  - An accepted sample with no change pushes nothing but still updates counters and sample_idx.
- FIFO:
  - Registered output with no fall-through: a record pushed at edge N has out_valid=1 no earlier than after edge N (visible in cycle N+1).
  - Pop = out_valid & out_ready.
  - Simultaneous push and pop are both performed; occupancy is unchanged.
  - When full, in_ready=0, so no sample is accepted or lost; counters freeze.
  - Pointers wrap modulo DEPTH.
  - out_data holds stable while out_valid=1 and out_ready=0.
- State machine on have_prev: EMPTY_HIST → (accept) → TRACKING; TRACKING → (clr or rst) → EMPTY_HIST.
- clr priority:
  - clr overrides a simultaneous accept or pop in the same cycle; that sample is discarded and counters are zeroed.
  - Next cycle out_valid=0 and in_ready=1.
- Reset mid-operation discards all pending records; there is no partial output.

Test Plan:
- Reset, then accept flags 0001, 0001, 0011 with out_ready=1 → two records: {idx0, 0001} and {idx2, 0011}; hit_q=3, hit_r=1.
- out_ready=0, present 5 alternating vectors 0000/1000 → 4 records stored; in_ready=0 after the 4th; the 5th is held until one pop, then accepted as idx4.
- Drive q_in=1 for 256 accepted samples with CNT_W=8 → hit_q=255, sat=1; 1 record only; sample_idx wraps to 0.
- FIFO holds 2 records; in the same cycle push a changed sample and pop → occupancy stays 2; records come out in order.
- Assert clr with 3 records queued and a valid changed sample → next cycle out_valid=0, all counters 0; the next accepted sample produces a record with idx0.
- Assert rst asynchronously mid-cycle while out_valid=1 → out_valid drops immediately, in_ready=1, hit_*=0.

Source files
------------

// File: rtl/cmb_event_collector.sv
`default_nettype none
// ============================================================================
// Module   : cmb_event_collector
// Purpose  : Sits downstream of the cmb flag decoder. Watches the {t,s,r,q}
//            flag vector, writes a timestamped record into a small FIFO every
//            time the vector changes, and keeps a saturating hit counter for
//            each flag.
// Ports    : clk, rst (async, active-high), clr (sync clear)
//            in_valid / in_ready       : flag-sample handshake
//            q_in, r_in, s_in, t_in    : decoder flags
//            out_valid / out_ready     : record handshake
//            out_data [CNT_W+3:0]      : {sample_idx, t, s, r, q}
//            hit_q/r/s/t [CNT_W-1:0]   : saturating per-flag hit counts
//            sat                       : sticky, some counter hit all-ones
// Revision : 1.0 - initial release
// ============================================================================
module cmb_event_collector #(
  parameter int CNT_W = 8,
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               q_in,
  input  logic               r_in,
  input  logic               s_in,
  input  logic               t_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CNT_W+3:0]   out_data,
  output logic [CNT_W-1:0]   hit_q,
  output logic [CNT_W-1:0]   hit_r,
  output logic [CNT_W-1:0]   hit_s,
  output logic [CNT_W-1:0]   hit_t,
  output logic               sat
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = PTR_W + 1;
  localparam int REC_W = CNT_W + 4;

  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};
  localparam logic [OCC_W-1:0] C_FULL    = OCC_W'(DEPTH);

  // History state machine: whether a previous vector exists to compare with.
  localparam logic [0:0] S_EMPTY_HIST = 1'b0;
  localparam logic [0:0] S_TRACKING   = 1'b1;

  logic [0:0]       state_q, state_d;
  logic             have_prev;

  logic [CNT_W-1:0] idx_q, idx_d;
  logic [3:0]       prev_q, prev_d;
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];
  logic             sat_q, sat_d;

  logic [REC_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;

  logic [3:0]       flags;
  logic             fifo_full;
  logic             accept;
  logic             push;
  logic             pop;

  assign flags     = {t_in, s_in, r_in, q_in};
  assign fifo_full = (occ_q == C_FULL);

  // in_ready depends only on FIFO occupancy, never on the other handshakes.
  assign in_ready  = ~fifo_full;
  assign out_valid = (occ_q != '0);
  // Zero while empty so the port reads 0 out of reset and after clr.
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;

  // clr wins over a same-cycle accept or pop: the sample is simply dropped.
  assign accept = in_valid & in_ready & ~clr;
  assign push   = accept & (~have_prev | (flags != prev_q));
  assign pop    = out_valid & out_ready & ~clr;

  // --------------------------------------------------------------------------
  // History FSM: state register / next-state / output
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_EMPTY_HIST;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_EMPTY_HIST: if (accept) state_d = S_TRACKING;
      S_TRACKING:   if (clr)    state_d = S_EMPTY_HIST;
      default:                  state_d = S_EMPTY_HIST;
    endcase
  end

  always_comb begin
    have_prev = (state_q == S_TRACKING);
  end

  // --------------------------------------------------------------------------
  // Sample index, previous vector, hit counters, sticky saturation
  // --------------------------------------------------------------------------
  always_comb begin
    idx_d  = idx_q;
    prev_d = prev_q;
    sat_d  = sat_q;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = cnt_q[i];
    end

    if (clr) begin
      idx_d  = '0;
      prev_d = '0;
      sat_d  = 1'b0;
      for (int i = 0; i < 4; i++) begin
        cnt_d[i] = '0;
      end
    end else if (accept) begin
      idx_d  = idx_q + CNT_W'(1);
      prev_d = flags;
      for (int i = 0; i < 4; i++) begin
        if (flags[i] && (cnt_q[i] != C_CNT_MAX)) begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
        if (cnt_d[i] == C_CNT_MAX) begin
          sat_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q  <= '0;
      prev_q <= '0;
      sat_q  <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      idx_q  <= idx_d;
      prev_q <= prev_d;
      sat_q  <= sat_d;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign hit_q = cnt_q[0];
  assign hit_r = cnt_q[1];
  assign hit_s = cnt_q[2];
  assign hit_t = cnt_q[3];
  assign sat   = sat_q;

  // --------------------------------------------------------------------------
  // Event FIFO. Storage is registered; a record written at an edge is only
  // visible after that edge, so there is no fall-through path from the flags.
  // Pointers wrap naturally because DEPTH is a power of two.
  // --------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   occ_d = occ_q + OCC_W'(1);
        2'b01:   occ_d = occ_q - OCC_W'(1);
        default: occ_d = occ_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Record storage needs no reset: out_data is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {idx_q, flags};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cmb_event_collector.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_cmb_event_collector
// Purpose  : Scoreboard bench for cmb_event_collector. Stimulus pushes the
//            expected event records into a queue; an independent monitor
//            pops and compares every record the DUT hands over.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cmb_event_collector;

  localparam int CNT_W = 8;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b0;
  logic in_valid = 1'b0;
  logic q_in = 1'b0, r_in = 1'b0, s_in = 1'b0, t_in = 1'b0;
  logic out_ready = 1'b0;
  logic in_ready, out_valid, sat;
  logic [CNT_W+3:0] out_data;
  logic [CNT_W-1:0] hit_q, hit_r, hit_s, hit_t;

  int checks = 0;
  int errors = 0;
  int pops   = 0;
  logic [CNT_W+3:0] last_pop = '0;
  logic [CNT_W+3:0] exp_q[$];

  // Reference model of the record generator
  logic [CNT_W-1:0] m_idx  = '0;
  logic [3:0]       m_prev = '0;
  logic             m_hp   = 1'b0;

  cmb_event_collector #(.CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready),
    .q_in(q_in), .r_in(r_in), .s_in(s_in), .t_in(t_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .hit_q(hit_q), .hit_r(hit_r), .hit_s(hit_s), .hit_t(hit_t),
    .sat(sat)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_idx  = '0;
    m_prev = '0;
    m_hp   = 1'b0;
    exp_q.delete();
  endtask

  // Monitor: the pop happens at the following rising edge.
  always @(negedge clk) begin
    if (!rst && !clr && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_record: got %0h expected none", out_data);
      end else begin
        check("record", 32'(out_data), 32'(exp_q.pop_front()));
      end
      last_pop = out_data;
      pops++;
    end
  end

  task automatic send(input logic [3:0] f);
    int n = 0;
    in_valid = 1'b1;
    {t_in, s_in, r_in, q_in} = f;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready=0 expected 1");
    end else begin
      if (!m_hp || f != m_prev) exp_q.push_back({m_idx, f});
      m_hp   = 1'b1;
      m_prev = f;
      m_idx  = m_idx + 1'b1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    out_ready = 1'b1;
    do begin
      @(posedge clk); #1;
      n++;
    end while ((exp_q.size() != 0 || out_valid) && n < 100);
    check({name, "_queue_empty"}, exp_q.size(), 0);
    check({name, "_out_valid"}, 32'(out_valid), 0);
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    pops = 0;
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_in_ready",  32'(in_ready),  1);
    check("rst_out_data",  32'(out_data),  0);
    check("rst_hit_q",     32'(hit_q),     0);
    check("rst_hit_t",     32'(hit_t),     0);
    check("rst_sat",       32'(sat),       0);

    // Basic change detection: 0001, 0001, 0011
    out_ready = 1'b1;
    send(4'b0001); send(4'b0001); send(4'b0011);
    drain("basic");
    check("basic_pops",  pops, 2);
    check("basic_last",  32'(last_pop), 32'h023);
    check("basic_hit_q", 32'(hit_q), 3);
    check("basic_hit_r", 32'(hit_r), 1);
    check("basic_hit_s", 32'(hit_s), 0);

    // Fill FIFO with out_ready=0, fifth sample waits for a single pop
    do_reset();
    send(4'b0000); send(4'b1000); send(4'b0000); send(4'b1000);
    check("full_in_ready0", 32'(in_ready), 0);
    check("full_out_valid", 32'(out_valid), 1);
    fork
      send(4'b0000);
      begin
        repeat (3) @(posedge clk); #1;
        check("full_in_ready1", 32'(in_ready), 0);
        check("full_hit_t_frozen", 32'(hit_t), 2);
        check("full_head_held", 32'(out_data), 32'h000);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
      end
    join
    check("full_again", 32'(in_ready), 0);
    drain("full");
    check("full_pops", pops, 5);
    check("full_last_idx4", 32'(last_pop), 32'h040);

    // Saturation and sample index wrap
    do_reset();
    out_ready = 1'b1;
    repeat (254) send(4'b0001);
    check("sat_hit_q_254", 32'(hit_q), 254);
    check("sat_not_yet",   32'(sat),   0);
    send(4'b0001);
    check("sat_hit_q_255", 32'(hit_q), 255);
    check("sat_set",       32'(sat),   1);
    send(4'b0001);
    check("sat_hit_q_hold", 32'(hit_q), 255);
    send(4'b0010);
    drain("sat");
    check("sat_pops", pops, 2);
    check("sat_wrap_idx0", 32'(last_pop), 32'h002);
    check("sat_sticky", 32'(sat), 1);
    check("sat_hit_r", 32'(hit_r), 1);

    // Simultaneous push and pop keeps occupancy
    do_reset();
    send(4'b0001); send(4'b0010);
    out_ready = 1'b1;
    send(4'b0100);
    out_ready = 1'b0;
    check("pp_pops", pops, 1);
    send(4'b1000);
    check("pp_occ3_ready", 32'(in_ready), 1);
    send(4'b0001);
    check("pp_occ4_full", 32'(in_ready), 0);
    drain("pp");
    check("pp_total_pops", pops, 5);

    // clr with queued records and a changed sample present
    do_reset();
    send(4'b0001); send(4'b0010); send(4'b0100);
    pops = 0;
    in_valid = 1'b1;
    {t_in, s_in, r_in, q_in} = 4'b1000;
    clr = 1'b1;
    out_ready = 1'b1;
    model_reset();
    @(posedge clk); #1;
    clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check("clr_out_valid", 32'(out_valid), 0);
    check("clr_in_ready",  32'(in_ready),  1);
    check("clr_hit_q",     32'(hit_q),     0);
    check("clr_hit_t",     32'(hit_t),     0);
    check("clr_sat",       32'(sat),       0);
    out_ready = 1'b1;
    send(4'b0101);
    drain("clr");
    check("clr_pops", pops, 1);
    check("clr_first_idx0", 32'(last_pop), 32'h005);

    // Asynchronous reset mid-cycle with a record pending
    do_reset();
    send(4'b1111);
    check("arst_pre_valid", 32'(out_valid), 1);
    check("arst_pre_hit_t", 32'(hit_t), 1);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("arst_out_valid", 32'(out_valid), 0);
    check("arst_in_ready",  32'(in_ready),  1);
    check("arst_hit_q",     32'(hit_q),     0);
    check("arst_hit_t",     32'(hit_t),     0);
    check("arst_out_data",  32'(out_data),  0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    drain("arst");
    check("arst_pops", pops, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
